// File: rtl/uart_axis_cmd_pkg.sv
// Shared types and constants for the UART AXI-Stream command front end.
package uart_axis_cmd_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ECHO    = 2'd1,
        ACK     = 2'd2
    } state_e;

    localparam byte_t ACK_BYTE = 8'h06;
    localparam byte_t NAK_BYTE = 8'h15;

endpackage

// File: rtl/uart_axis_cmd_decode.sv
// Combinational command decoder: compares a packed word against the on/off
// base ranges and the all-off word. Priority is on > off > all-off.
module uart_axis_cmd_decode #(
    parameter int          WW       = 32,
    parameter int          CH       = 5,
    parameter logic [63:0] ON_BASE  = 64'h00B835F2,
    parameter logic [63:0] OFF_BASE = 64'hC0C0FFEE,
    parameter logic [63:0] ALL_OFF  = 64'hDEADBEEF
) (
    input  logic [WW-1:0] i_word,
    output logic [CH-1:0] o_set,
    output logic [CH-1:0] o_clr,
    output logic          o_match
);

    // Bases are truncated to the word width so that base+k wraps modulo 2^WW.
    localparam logic [WW-1:0] ON_W  = ON_BASE[WW-1:0];
    localparam logic [WW-1:0] OFF_W = OFF_BASE[WW-1:0];
    localparam logic [WW-1:0] ALL_W = ALL_OFF[WW-1:0];

    logic [CH-1:0] w_on;
    logic [CH-1:0] w_off;

    // Per-channel hit vectors, then resolve priority into one set or clear mask.
    always_comb begin
        w_on    = '0;
        w_off   = '0;
        o_set   = '0;
        o_clr   = '0;
        o_match = 1'b0;
        for (int k = 0; k < CH; k++) begin
            w_on[k]  = (i_word == ON_W  + WW'(k));
            w_off[k] = (i_word == OFF_W + WW'(k));
        end
        if (|w_on) begin
            o_set   = w_on;
            o_match = 1'b1;
        end else if (|w_off) begin
            o_clr   = w_off;
            o_match = 1'b1;
        end else if (i_word == ALL_W) begin
            o_clr   = '1;
            o_match = 1'b1;
        end
    end

endmodule

// File: rtl/uart_axis_cmd.sv
// UART byte-stream command front end: packs word_bytes_p bytes (first byte
// in the LSB lane), decodes LED set/clear commands, echoes the word back on
// an 8-bit AXI-Stream master and drops stale partial words after a timeout.
// Optional macro UART_AXIS_CMD_ACK_EN appends an ACK/NAK byte to each echo.
module uart_axis_cmd
    import uart_axis_cmd_pkg::*;
#(
    parameter int          word_bytes_p     = 4,
    parameter int          channels_p       = 5,
    parameter logic [63:0] on_base_p        = 64'h00B835F2,
    parameter logic [63:0] off_base_p       = 64'hC0C0FFEE,
    parameter logic [63:0] all_off_p        = 64'hDEADBEEF,
    parameter int          timeout_cycles_p = 100000
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [7:0]            s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    output logic [7:0]            m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    input  logic                  m_axis_tready_i,
    output logic [channels_p-1:0] led_o,
    output logic                  match_o,
    output logic                  drop_o
);

    localparam int             CW   = $clog2(word_bytes_p);
    localparam logic [CW-1:0]  LAST = CW'(word_bytes_p - 1);

    state_e                    r_state, w_state_nxt;
    byte_t [word_bytes_p-2:0]  r_buf;
    byte_t [word_bytes_p-1:0]  r_word;
    byte_t [word_bytes_p-1:0]  w_word;
    logic  [CW-1:0]            r_cnt;
    logic  [CW-1:0]            r_idx;
    logic  [31:0]              r_tmo;
    logic  [channels_p-1:0]    r_led;
    logic  [channels_p-1:0]    w_set;
    logic  [channels_p-1:0]    w_clr;
    logic                      r_match;
    logic                      r_drop;
    logic                      w_hit;
    logic                      w_s_hs;
    logic                      w_m_hs;
    logic                      w_tmo_fire;
`ifdef UART_AXIS_CMD_ACK_EN
    logic                      r_hit;
`endif

    assign w_s_hs = s_axis_tvalid_i & s_axis_tready_o;
    assign w_m_hs = m_axis_tvalid_o & m_axis_tready_i;

    // The last lane comes straight from the input so decode sees the whole
    // word on the accepting edge.
    assign w_word = {s_axis_tdata_i, r_buf};

    uart_axis_cmd_decode #(
        .WW       (8 * word_bytes_p),
        .CH       (channels_p),
        .ON_BASE  (on_base_p),
        .OFF_BASE (off_base_p),
        .ALL_OFF  (all_off_p)
    ) u_decode (
        .i_word  (w_word),
        .o_set   (w_set),
        .o_clr   (w_clr),
        .o_match (w_hit)
    );

    // Timeout fires on the idle cycle that would bring the counter to the limit.
    generate
        if (timeout_cycles_p > 0) begin : g_tmo
            assign w_tmo_fire = (r_state == COLLECT) && (r_cnt != '0) && !w_s_hs &&
                                (r_tmo == 32'(timeout_cycles_p - 1));
        end else begin : g_no_tmo
            assign w_tmo_fire = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) r_state <= COLLECT;
        else           r_state <= w_state_nxt;
    end

    // Next state and stream handshake outputs.
    always_comb begin
        w_state_nxt     = r_state;
        s_axis_tready_o = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = '0;
        m_axis_tlast_o  = 1'b0;
        case (r_state)
            COLLECT: begin
                s_axis_tready_o = 1'b1;
                if (s_axis_tvalid_i && r_cnt == LAST) w_state_nxt = ECHO;
            end
            ECHO: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = r_word[r_idx];
`ifdef UART_AXIS_CMD_ACK_EN
                if (m_axis_tready_i && r_idx == LAST) w_state_nxt = ACK;
`else
                m_axis_tlast_o  = (r_idx == LAST);
                if (m_axis_tready_i && r_idx == LAST) w_state_nxt = COLLECT;
`endif
            end
`ifdef UART_AXIS_CMD_ACK_EN
            ACK: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = r_hit ? ACK_BYTE : NAK_BYTE;
                m_axis_tlast_o  = 1'b1;
                if (m_axis_tready_i) w_state_nxt = COLLECT;
            end
`endif
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Byte packing, decode results, timeout counter and echo index.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_buf   <= '0;
            r_word  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_led   <= '0;
            r_match <= 1'b0;
            r_drop  <= 1'b0;
`ifdef UART_AXIS_CMD_ACK_EN
            r_hit   <= 1'b0;
`endif
        end else begin
            r_match <= 1'b0;
            r_drop  <= 1'b0;
            if (w_s_hs) begin
                r_tmo <= '0;
                if (r_cnt == LAST) begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_word  <= w_word;
                    r_led   <= (r_led | w_set) & ~w_clr;
                    r_match <= w_hit;
`ifdef UART_AXIS_CMD_ACK_EN
                    r_hit   <= w_hit;
`endif
                end else begin
                    r_buf[r_cnt] <= s_axis_tdata_i;
                    r_cnt        <= r_cnt + 1'b1;
                end
            end else if (r_state == COLLECT && r_cnt != '0) begin
                if (w_tmo_fire) begin
                    r_cnt  <= '0;
                    r_tmo  <= '0;
                    r_drop <= 1'b1;
                end else begin
                    r_tmo  <= r_tmo + 1'b1;
                end
            end
            if (w_m_hs && r_state == ECHO) begin
                r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign led_o   = r_led;
    assign match_o = r_match;
    assign drop_o  = r_drop;

endmodule

// File: doc/uart_axis_cmd.md
Name: uart_axis_cmd

Overview:
- Byte-stream command front end that sits directly behind the UART receiver's 8-bit AXI-Stream master port.
- Packs word_bytes_p received bytes into one command word, first byte in the least-significant lane.
- Decodes the word into per-channel LED set/clear actions and echoes the word back byte-by-byte on an 8-bit AXI-Stream master toward the UART transmitter.
- Discards stale partial words after an inter-byte timeout.
- Replaces the fixed 4-byte, single-LED packer/adapter arrangement.

Parameters:
- word_bytes_p, 4: bytes per command word, 2..8; word width ww = 8*word_bytes_p.
- channels_p, 5: number of LED channels, 1..32.
- on_base_p, 64'h00B835F2: word equal to on_base_p+k sets led k; truncated to ww.
- off_base_p, 64'hC0C0FFEE: word equal to off_base_p+k clears led k; truncated to ww.
- all_off_p, 64'hDEADBEEF: word that clears all channels; truncated to ww.
- timeout_cycles_p, 100000: idle cycles before a partial word is dropped; 0 disables the timeout.

Ports:
- clk_i, input, 1: clock, single domain.
- reset_ni, input, 1: synchronous, active-low reset.
- s_axis_tdata_i, input, 8: received byte.
- s_axis_tvalid_i, input, 1: received byte valid.
- s_axis_tready_o, output, 1: ready to accept a received byte.
- m_axis_tdata_o, output, 8: echo byte.
- m_axis_tvalid_o, output, 1: echo byte valid.
- m_axis_tlast_o, output, 1: final byte of the echo frame.
- m_axis_tready_i, input, 1: echo sink ready.
- led_o, output, channels_p: channel states.
- match_o, output, 1: one-cycle pulse when a word decoded to a command.
- drop_o, output, 1: one-cycle pulse when a partial word was discarded.

Behaviour:
- Reset (reset_ni low at a clk_i edge): state COLLECT, byte count 0, timeout counter 0. All outputs 0 except s_axis_tready_o, which is 1 from the first cycle after reset. Reset mid-frame drops all partial and echo data.
- States: COLLECT, ECHO, and ACK (ACK exists only with the optional feature).
- COLLECT:
  - s_axis_tready_o=1, m_axis_tvalid_o=0.
  - On each handshake the byte is stored in lane count and count increments.
  - When the handshake is on lane word_bytes_p-1: the word is latched, decode is applied, count returns to 0, next state is ECHO.
- Decode, applied on the edge that accepts the last byte; led_o and match_o change the following cycle:
  - Priority on > off > all_off.
  - Word equals on_base_p+k with k<channels_p: led k set.
  - Else word equals off_base_p+k: led k clears.
  - Else word equals all_off_p: all leds clear.
  - Otherwise no change and match_o stays 0.
  - Additions are modulo 2^ww.
- ECHO:
  - s_axis_tready_o=0.
  - m_axis_tvalid_o=1 starting the cycle after the last byte is accepted; m_axis_tdata_o is lane idx, idx starting at 0.
  - m_axis_tlast_o=1 only when idx=word_bytes_p-1.
  - Data and tlast stay stable while tready is low.
  - On each handshake idx increments. The handshake on the last lane moves to COLLECT, or to ACK when the feature is enabled.
  - Next frame's first byte can be accepted in the cycle after the last echo handshake.
- Timeout:
  - Counter clears on every accepted byte.
  - Counter increments each COLLECT cycle with count>0 and no handshake.
  - When it reaches timeout_cycles_p: count and counter clear, and drop_o is high for exactly the next cycle.
  - A handshake in the same cycle takes priority: the byte is accepted and there is no drop.
  - The counter is frozen in ECHO and ACK.
- Throughput: one word per word_bytes_p input plus word_bytes_p output handshakes. There is no internal FIFO; backpressure propagates to the UART through s_axis_tready_o.

Optional Feature:
- Macro UART_AXIS_CMD_ACK_EN.
- When defined: after the echo frame, state ACK emits one extra byte, 8'h06 if the word matched or 8'h15 if not. In this configuration tlast is asserted on the ACK byte instead of the last echo byte; the ACK handshake returns to COLLECT.
- When undefined: the ACK state and logic are absent; behaviour is exactly as above.

Decomposition:
- Package uart_axis_cmd_pkg holds:
  - state enum typedef (COLLECT, ECHO, ACK);
  - ACK_BYTE 8'h06 and NAK_BYTE 8'h15 constants;
  - byte_t typedef.
- Sub-module uart_axis_cmd_decode: combinational word/parameter compare. Produces a set mask, a clear mask and the match flag; the top level registers the results.

Test Plan:
- Reset: hold reset_ni low 5 cycles with random stimulus, then release → led_o=0, m_axis_tvalid_o=0, drop_o=0, s_axis_tready_o=1.
- Send F2 35 B8 00 → led_o=5'b00001 one cycle after the 4th handshake, match_o pulses once, echo F2 35 B8 00 with tlast only on 00.
- Send on_base+2 (F4 35 B8 00), then off_base+2 (F0 FF C0 C0), then DEADBEEF with led 0 set → led_o 00101, then 00001, then 00000.
- Send F2 35 then 120000 idle cycles → drop_o pulses once and no echo; next full word F2 35 B8 00 decodes correctly. Repeat with a byte arriving exactly on the timeout cycle → no drop.
- Backpressure: m_axis_tready_i low 10 cycles mid-echo → tdata/tlast stable, s_axis_tready_o=0, no bytes lost or duplicated. Assert reset_ni low mid-echo → clean restart.
- With UART_AXIS_CMD_ACK_EN: matched word → echo plus 06 with tlast on 06; unmatched 11 22 33 44 → echo plus 15, led_o unchanged.
